// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter.
// Drives the shared open-drain clock/data pins to send one command byte to
// the keyboard and checks the device acknowledge. The receiver must be
// masked while busy is high.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | lines released, tx_ready=1, waiting for tx_req
// INHIBIT   | clock held low to stop any device traffic
// REQ       | clock and data held low (request-to-send, start bit)
// SHIFT     | clock released, next bit placed on data at each device fall
// ACK       | stop bit released, device acknowledge sampled at next fall
// WAIT_IDLE | waiting for both lines to return high before reporting
module ps2_host_tx #(
  parameter int CLK_FREQ   = 28_000_000,
  parameter int INHIBIT_US = 120,
  parameter int TIMEOUT_US = 15000,
  parameter int FILT       = 16
) (
  input  logic       clk28,
  input  logic       rst_n,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_req,
  output logic       tx_ready,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int CYC_US  = CLK_FREQ / 1_000_000;
  localparam int INH_CYC = INHIBIT_US * CYC_US;
  localparam int WD_CYC  = TIMEOUT_US * CYC_US;
  localparam int TMR_MAX = (INH_CYC > CYC_US) ? INH_CYC : CYC_US;
  localparam int TW      = $clog2(TMR_MAX + 1);
  localparam int WW      = $clog2(WD_CYC + 1);
  localparam int FW      = $clog2(FILT + 1);

  localparam logic [TW-1:0] INH_LD  = TW'(INH_CYC - 1);
  localparam logic [TW-1:0] REQ_LD  = TW'(CYC_US - 1);
  localparam logic [WW-1:0] WD_LD   = WW'(WD_CYC - 1);
  localparam logic [FW-1:0] FILT_TC = FW'(FILT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_SHIFT, S_ACK, S_WAIT_IDLE
  } state_t;

  // bit 0 = clock pin, bit 1 = data pin
  logic [1:0] pin_raw, pin_s1, pin_s2, pin_f;
  logic       clk_f, dat_f, clk_f_d, fall;

  state_t     state, state_nx;
  logic [TW-1:0] tmr, tmr_nx;
  logic [WW-1:0] wd, wd_nx;
  logic [3:0] bit_n, bit_n_nx;
  logic [7:0] data_q, data_nx;
  logic       par, par_nx, ok, ok_nx;
  logic       clk_oe_q, clk_oe_nx, dat_oe_q, dat_oe_nx;
  logic       done_q, done_nx, err_q, err_nx;

  assign pin_raw = {ps2_dat_in, ps2_clk_in};

  // Two-flop synchronizer for both pins; idle level is high.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      pin_s1 <= 2'b11;
      pin_s2 <= 2'b11;
    end else begin
      pin_s1 <= pin_raw;
      pin_s2 <= pin_s1;
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_filt
    logic [FW-1:0] cnt;
    logic          lvl;
    // Filtered level follows the pin only after FILT consecutive disagreeing samples.
    always_ff @(posedge clk28 or negedge rst_n) begin
      if (!rst_n) begin
        cnt <= '0;
        lvl <= 1'b1;
      end else if (pin_s2[g] == lvl) begin
        cnt <= '0;
      end else if (cnt == FILT_TC) begin
        cnt <= '0;
        lvl <= pin_s2[g];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
    assign pin_f[g] = lvl;
  end

  assign clk_f = pin_f[0];
  assign dat_f = pin_f[1];

  // Delayed filtered clock for the falling-edge strobe.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) clk_f_d <= 1'b1;
    else        clk_f_d <= clk_f;
  end

  assign fall = clk_f_d & ~clk_f;

  // State and datapath registers; pins reset to released asynchronously.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      tmr      <= '0;
      wd       <= '0;
      bit_n    <= '0;
      data_q   <= '0;
      par      <= 1'b0;
      ok       <= 1'b0;
      clk_oe_q <= 1'b0;
      dat_oe_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_nx;
      tmr      <= tmr_nx;
      wd       <= wd_nx;
      bit_n    <= bit_n_nx;
      data_q   <= data_nx;
      par      <= par_nx;
      ok       <= ok_nx;
      clk_oe_q <= clk_oe_nx;
      dat_oe_q <= dat_oe_nx;
      done_q   <= done_nx;
      err_q    <= err_nx;
    end
  end

  // Next-state, pin drive and result pulses; watchdog overrides everything.
  always_comb begin
    state_nx  = state;
    tmr_nx    = tmr;
    wd_nx     = wd;
    bit_n_nx  = bit_n;
    data_nx   = data_q;
    par_nx    = par;
    ok_nx     = ok;
    clk_oe_nx = clk_oe_q;
    dat_oe_nx = dat_oe_q;
    done_nx   = 1'b0;
    err_nx    = 1'b0;

    case (state)
      S_IDLE: begin
        clk_oe_nx = 1'b0;
        dat_oe_nx = 1'b0;
        if (tx_req) begin
          data_nx   = tx_data;
          par_nx    = ~^tx_data;
          tmr_nx    = INH_LD;
          clk_oe_nx = 1'b1;
          state_nx  = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (tmr == '0) begin
          dat_oe_nx = 1'b1;
          tmr_nx    = REQ_LD;
          state_nx  = S_REQ;
        end else begin
          tmr_nx = tmr - 1'b1;
        end
      end
      S_REQ: begin
        if (tmr == '0) begin
          clk_oe_nx = 1'b0;
          bit_n_nx  = '0;
          wd_nx     = WD_LD;
          state_nx  = S_SHIFT;
        end else begin
          tmr_nx = tmr - 1'b1;
        end
      end
      S_SHIFT: begin
        if (fall) begin
          bit_n_nx = bit_n + 1'b1;
          if (bit_n < 4'd8) begin
            dat_oe_nx = ~data_q[bit_n[2:0]];
          end else if (bit_n == 4'd8) begin
            dat_oe_nx = ~par;
          end else begin
            dat_oe_nx = 1'b0;
            state_nx  = S_ACK;
          end
        end
      end
      S_ACK: begin
        if (fall) begin
          ok_nx    = ~dat_f;
          state_nx = S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        if (clk_f && dat_f) begin
          done_nx  = ok;
          err_nx   = ~ok;
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase

    if (state == S_SHIFT || state == S_ACK || state == S_WAIT_IDLE) begin
      if (wd == '0) begin
        state_nx  = S_IDLE;
        clk_oe_nx = 1'b0;
        dat_oe_nx = 1'b0;
        done_nx   = 1'b0;
        err_nx    = 1'b1;
      end else begin
        wd_nx = wd - 1'b1;
      end
    end
  end

  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;
  assign tx_ready   = (state == S_IDLE);
  assign busy       = ~tx_ready;
  assign tx_done    = done_q;
  assign tx_error   = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the DUT;
// expected frames and outcomes are queued at request time and matched by
// independent monitors.
module tb_ps2_host_tx;

  localparam int CLK_FREQ   = 8_000_000;
  localparam int INHIBIT_US = 60;
  localparam int TIMEOUT_US = 1000;
  localparam int FILT       = 16;
  localparam int CYC        = CLK_FREQ / 1_000_000;
  localparam int INH        = INHIBIT_US * CYC;
  localparam int WD         = TIMEOUT_US * CYC;
  localparam int H          = 60;
  localparam int DEV_DLY    = 20;

  logic       clk28 = 1'b0;
  logic       rst_n = 1'b0;
  logic       dev_clk = 1'b1, dev_dat = 1'b1;
  logic       ps2_clk_in, ps2_dat_in, ps2_clk_oe, ps2_dat_oe;
  logic [7:0] tx_data = 8'h00;
  logic       tx_req = 1'b0;
  logic       tx_ready, busy, tx_done, tx_error;

  assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
  assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

  ps2_host_tx #(
    .CLK_FREQ(CLK_FREQ), .INHIBIT_US(INHIBIT_US),
    .TIMEOUT_US(TIMEOUT_US), .FILT(FILT)
  ) dut (
    .clk28(clk28), .rst_n(rst_n),
    .ps2_clk_in(ps2_clk_in), .ps2_dat_in(ps2_dat_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe),
    .tx_data(tx_data), .tx_req(tx_req), .tx_ready(tx_ready),
    .busy(busy), .tx_done(tx_done), .tx_error(tx_error)
  );

  always #5 clk28 = ~clk28;

  int cyc = 0;
  always @(posedge clk28) cyc <= cyc + 1;

  typedef struct { bit is_err; bit chk_wd; } exp_t;
  exp_t        exp_out[$];
  logic [10:0] exp_frm[$];
  logic [10:0] obs_frm[$];

  int vectors = 0, miscompares = 0;
  int dev_mode = 0;
  bit dev_glitch = 1'b0;
  int dev_falls = 0;
  bit dev_active = 1'b0;
  int t_clk_rise = 0, t_dat_rise = 0, t_release = 0;

  function automatic void check(string name, int act, int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Frame as seen on the wire: start, D0..D7, odd parity, stop.
  function automatic logic [10:0] ref_frame(input logic [7:0] d);
    logic [10:0] f;
    int ones;
    ones = 0;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      f[i+1] = d[i];
      ones += int'(d[i]);
    end
    f[9]  = (ones % 2 == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  // Device model: senses request, clocks 11 bits, optionally acknowledges.
  initial begin
    forever begin
      @(negedge clk28);
      if (rst_n && ps2_clk_in && !ps2_dat_in) begin
        logic [10:0] bits;
        bit ab;
        int mode, w;
        bit gl;
        mode = dev_mode;
        gl = dev_glitch;
        dev_active = 1'b1;
        dev_falls = 0;
        ab = 1'b0;
        bits = '0;
        if (mode == 2) begin
          w = 0;
          while (!ps2_dat_in && w < WD + 1000) begin
            @(negedge clk28);
            w++;
          end
        end else begin
          repeat (DEV_DLY) @(negedge clk28);
          bits[0] = ps2_dat_in;
          for (int k = 1; k <= 11 && !ab; k++) begin
            dev_clk = 1'b0;
            dev_falls = k;
            repeat (H) @(negedge clk28);
            if (!rst_n) ab = 1'b1;
            else begin
              dev_clk = 1'b1;
              if (k <= 10) bits[k] = ps2_dat_in;
              if (gl && k == 3) begin
                repeat (20) @(negedge clk28);
                dev_clk = 1'b0;
                repeat (10) @(negedge clk28);
                dev_clk = 1'b1;
                repeat (H - 30) @(negedge clk28);
              end else if (k == 10 && mode == 0) begin
                repeat (10) @(negedge clk28);
                dev_dat = 1'b0;
                repeat (H - 10) @(negedge clk28);
              end else begin
                repeat (H) @(negedge clk28);
              end
              if (!rst_n) ab = 1'b1;
            end
          end
          dev_clk = 1'b1;
          dev_dat = 1'b1;
          if (!ab) obs_frm.push_back(bits);
        end
        dev_active = 1'b0;
      end
    end
  end

  // Frame monitor.
  initial begin
    forever begin
      @(negedge clk28);
      if (obs_frm.size() > 0) begin
        logic [10:0] o, e;
        o = obs_frm.pop_front();
        if (exp_frm.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL frame: got unexpected frame %b, required none", o);
        end else begin
          e = exp_frm.pop_front();
          check("frame_bits", int'(o), int'(e));
        end
      end
    end
  end

  // Outcome monitor.
  initial begin
    forever begin
      @(negedge clk28);
      if (tx_done || tx_error) begin
        if (exp_out.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL outcome: got pulse done=%0b error=%0b, required none", tx_done, tx_error);
        end else begin
          exp_t e;
          e = exp_out.pop_front();
          check("outcome_done", int'(tx_done), int'(!e.is_err));
          check("outcome_error", int'(tx_error), int'(e.is_err));
          check("ready_at_pulse", int'(tx_ready), 1);
          check("busy_at_pulse", int'(busy), 0);
          check("oe_at_pulse", int'({ps2_clk_oe, ps2_dat_oe}), 0);
          if (e.chk_wd) check("watchdog_cycles", cyc - t_release, WD);
        end
      end
    end
  end

  // Request-sequence timing monitor.
  initial begin
    logic pc, pd;
    pc = 1'b0;
    pd = 1'b0;
    forever begin
      @(negedge clk28);
      if (ps2_clk_oe && !pc) t_clk_rise = cyc;
      if (ps2_dat_oe && !pd && ps2_clk_oe) begin
        t_dat_rise = cyc;
        check("inhibit_cycles", t_dat_rise - t_clk_rise, INH);
      end
      if (!ps2_clk_oe && pc && rst_n) begin
        t_release = cyc;
        check("req_cycles", t_release - t_dat_rise, CYC);
      end
      pc = ps2_clk_oe;
      pd = ps2_dat_oe;
    end
  end

  task automatic wait_idle();
    int w;
    w = 0;
    while ((busy || dev_active) && w < 3 * WD) begin
      @(negedge clk28);
      w++;
    end
    if (w >= 3 * WD) begin
      vectors++;
      miscompares++;
      $display("FAIL idle_timeout: got busy=%0b after %0d cycles, required 0", busy, w);
    end
    repeat (50) @(negedge clk28);
  endtask

  task automatic send(input logic [7:0] d, input int mode, input bit gl, input bit inj);
    exp_t e;
    int w;
    @(negedge clk28);
    dev_mode = mode;
    dev_glitch = gl;
    if (mode != 2) exp_frm.push_back(ref_frame(d));
    e.is_err = (mode != 0);
    e.chk_wd = (mode == 2);
    exp_out.push_back(e);
    tx_data = d;
    tx_req = 1'b1;
    @(negedge clk28);
    tx_req = 1'b0;
    tx_data = 8'($urandom);
    check("accept_ready", int'(tx_ready), 0);
    check("accept_busy", int'(busy), 1);
    check("accept_clk_oe", int'(ps2_clk_oe), 1);
    if (inj) begin
      w = 0;
      while (!(dev_active && dev_falls == 4) && w < 5000) begin
        @(negedge clk28);
        w++;
      end
      check("busy_at_inject", int'(busy), 1);
      tx_data = ~d;
      tx_req = 1'b1;
      @(negedge clk28);
      tx_req = 1'b0;
    end
    wait_idle();
  endtask

  task automatic reset_mid_frame();
    int w;
    @(negedge clk28);
    dev_mode = 0;
    dev_glitch = 1'b0;
    tx_data = 8'h00;
    tx_req = 1'b1;
    @(negedge clk28);
    tx_req = 1'b0;
    w = 0;
    while (!(dev_active && dev_falls == 5) && w < 5000) begin
      @(negedge clk28);
      w++;
    end
    repeat (30) @(negedge clk28);
    check("pre_reset_dat_oe", int'(ps2_dat_oe), 1);
    check("pre_reset_busy", int'(busy), 1);
    @(posedge clk28);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_oe", int'({ps2_clk_oe, ps2_dat_oe}), 0);
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_ready", int'(tx_ready), 1);
    repeat (100) @(negedge clk28);
    rst_n = 1'b1;
    repeat (20) @(negedge clk28);
    check("post_rst_ready", int'(tx_ready), 1);
    wait_idle();
    repeat (300) @(negedge clk28);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish by t=%0t, required finish", $time);
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "simulation time limit");
  end

  initial begin
    repeat (5) @(negedge clk28);
    check("rst_ready", int'(tx_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_oe", int'({ps2_clk_oe, ps2_dat_oe}), 0);
    check("rst_pulses", int'({tx_done, tx_error}), 0);
    rst_n = 1'b1;
    repeat (50) @(negedge clk28);

    send(8'hED, 0, 1'b0, 1'b0);
    send(8'h00, 0, 1'b0, 1'b0);
    send(8'h01, 0, 1'b0, 1'b0);
    send(8'hA5, 1, 1'b0, 1'b0);
    send(8'h3C, 2, 1'b0, 1'b0);
    send(8'h5A, 0, 1'b1, 1'b0);
    send(8'h96, 0, 1'b0, 1'b1);
    reset_mid_frame();
    for (int i = 0; i < 10; i++) begin
      send(8'($urandom), ($urandom_range(0, 4) == 0) ? 1 : 0,
           1'($urandom_range(0, 1)), 1'b0);
    end

    repeat (2000) @(negedge clk28);
    check("leftover_exp_frames", exp_frm.size(), 0);
    check("leftover_exp_outcomes", exp_out.size(), 0);
    check("leftover_obs_frames", obs_frm.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
